// File: rtl/wb_ram_slave.sv
// Wishbone B4 pipelined slave RAM: word-organised storage with byte enables,
// a fixed-latency in-order ack pipeline and a stall-based outstanding limit.
module wb_ram_slave #(
    parameter int DEPTH_WORDS     = 1024,
    parameter int LATENCY         = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    input  logic        wb_cyc_i,
    output logic        wb_stall_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    logic [31:0]        mem [DEPTH_WORDS];
    logic [AW-1:0]      word_idx;
    logic [31:0]        rd_word;
    logic               accept;
    logic               flush;
    logic [CW-1:0]      outstanding;
    logic [LATENCY-1:0] pipe_vld;
    logic [31:0]        pipe_dat [LATENCY];
    logic               unused_adr;

    // Byte offset and bits above the RAM span are ignored, so addresses wrap.
    assign word_idx   = wb_adr_i[AW+1:2];
    assign unused_adr = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0]};

    assign wb_stall_o = (outstanding == CNT_MAX);
    assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
    assign flush      = rst_i | ~wb_cyc_i;

    assign wb_ack_o = pipe_vld[LATENCY-1];
    assign wb_dat_o = pipe_dat[LATENCY-1];
    assign rd_word  = mem[word_idx];

    always_ff @(posedge clk_i) begin
        if (accept && wb_we_i && !rst_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) begin
                    mem[word_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    // Write acks carry zero so the output data is zero whenever it is not a read ack.
    always_ff @(posedge clk_i) begin
        if (flush) begin
            pipe_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= accept;
            pipe_dat[0] <= (accept && !wb_we_i) ? rd_word : 32'h0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (flush) begin
            outstanding <= '0;
        end else if (accept && !wb_ack_o) begin
            outstanding <= outstanding + CW'(1);
        end else if (!accept && wb_ack_o) begin
            outstanding <= outstanding - CW'(1);
        end
    end
endmodule

// File: tb/tb_wb_ram_slave.sv
// Scoreboard bench for wb_ram_slave: three latency/outstanding configurations
// driven with directed and random traffic against an array-based memory model.
`timescale 1ns/1ps
module tb_wb_ram_slave;
    typedef struct {
        logic        rd;
        logic [31:0] data;
        int          acc;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 4;
        localparam int M = (g == 2) ? 2 : 4;

        logic        rst  = 1'b1;
        logic        cyc  = 1'b0;
        logic        stb  = 1'b0;
        logic        we   = 1'b0;
        logic [31:0] adr  = '0;
        logic [31:0] wdat = '0;
        logic [3:0]  sel  = '0;
        logic [31:0] rdat;
        logic        ack;
        logic        stall;
        logic        mon_en = 1'b0;
        logic        fin = 1'b0;
        logic [31:0] mdl [1024];
        exp_t        q [$];

        wb_ram_slave #(
            .DEPTH_WORDS(1024), .LATENCY(L), .MAX_OUTSTANDING(M)
        ) dut (
            .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat),
            .wb_dat_o(rdat), .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb),
            .wb_ack_o(ack), .wb_cyc_i(cyc), .wb_stall_o(stall)
        );

        // Called at posedge+1: presents a request and holds it until accepted.
        task automatic op(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
            exp_t e;
            int   idx;
            int   n;
            cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
            n = 0;
            while (stall !== 1'b0 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            if (n >= 100) begin
                checks++; errors++;
                $display("FAIL L%0d op_timeout actual=stalled required=accept", L);
                stb = 1'b0;
                return;
            end
            idx   = (a >> 2) & 1023;
            e.rd  = !w;
            e.acc = edge_n + 1;
            e.due = edge_n + L;
            if (w) begin
                for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
                e.data = 32'h0;
            end else begin
                e.data = mdl[idx];
            end
            q.push_back(e);
            @(posedge clk); #1;
            stb = 1'b0;
        endtask

        task automatic idle(input int n);
            stb = 1'b0;
            repeat (n) begin @(posedge clk); #1; end
        endtask

        always @(negedge clk) begin
            int   o;
            exp_t e;
            if (mon_en) begin
                o = 0;
                foreach (q[i]) if (q[i].acc <= edge_n) o++;
                chk($sformatf("L%0d stall", L), {31'b0, stall}, {31'b0, (o == M)});
                if (ack === 1'b1) begin
                    if (q.size() == 0) begin
                        chk($sformatf("L%0d spurious_ack", L), {31'b0, ack}, 32'h0);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("L%0d ack_edge", L), edge_n, e.due);
                        chk($sformatf("L%0d ack_data rd=%0b", L, e.rd), rdat, e.data);
                    end
                end else begin
                    chk($sformatf("L%0d idle_dat", L), rdat, 32'h0);
                    if (q.size() > 0 && q[0].due <= edge_n) begin
                        chk($sformatf("L%0d missing_ack", L), {31'b0, ack}, 32'h1);
                        void'(q.pop_front());
                    end
                end
            end
        end

        initial begin
            int n;
            rst = 1'b1; cyc = 1'b0; stb = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0; cyc = 1'b1;
            chk($sformatf("L%0d reset_ack", L), {31'b0, ack}, 32'h0);
            chk($sformatf("L%0d reset_dat", L), rdat, 32'h0);
            chk($sformatf("L%0d reset_stall", L), {31'b0, stall}, 32'h0);
            mon_en = 1'b1;

            // Byte-enable merge.
            op(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
            op(1'b1, 32'h10, 32'h000000AA, 4'b0001);
            op(1'b0, 32'h10, 32'h0, 4'b1111);
            idle(L + 2);

            for (int i = 0; i < 16; i++) op(1'b1, i * 4, $urandom, 4'hF);
            idle(L + 2);

            // Address wrap and ignored byte offset.
            op(1'b1, 32'h0000_1004, 32'h12345678, 4'hF);
            op(1'b0, 32'h0000_0004, 32'h0, 4'hF);
            op(1'b0, 32'h0000_0007, 32'h0, 4'h0);
            idle(L + 2);

            for (int i = 0; i < 4; i++) op(1'b0, i * 4, 32'h0, 4'hF);
            idle(L + 2);
            for (int i = 0; i < 6; i++) op(1'b0, (i % 16) * 4, 32'h0, 4'hF);
            idle(L + 2);

            for (int i = 0; i < 200; i++) begin
                logic [31:0] a;
                a = ($urandom & 32'hFFFF_F000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
                op(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
                if ($urandom_range(0, 9) < 3) idle($urandom_range(1, 3));
            end
            idle(L + 2);

            // Cycle abort with reads in flight.
            op(1'b0, 32'h0, 32'h0, 4'hF);
            op(1'b0, 32'h4, 32'h0, 4'hF);
            cyc = 1'b0; stb = 1'b0;
            @(posedge clk); #1;
            q.delete();
            cyc = 1'b1;
            chk($sformatf("L%0d abort_stall", L), {31'b0, stall}, 32'h0);
            idle(L + 4);
            op(1'b0, 32'h8, 32'h0, 4'hF);
            idle(L + 2);

            // Reset with requests pending; earlier write must survive.
            op(1'b1, 32'h20, 32'hCAFE0123, 4'hF);
            op(1'b0, 32'h24, 32'h0, 4'hF);
            op(1'b0, 32'h28, 32'h0, 4'hF);
            rst = 1'b1; stb = 1'b0;
            @(posedge clk); #1;
            q.delete();
            rst = 1'b0;
            chk($sformatf("L%0d midrst_ack", L), {31'b0, ack}, 32'h0);
            chk($sformatf("L%0d midrst_dat", L), rdat, 32'h0);
            chk($sformatf("L%0d midrst_stall", L), {31'b0, stall}, 32'h0);
            idle(L + 4);
            op(1'b0, 32'h20, 32'h0, 4'hF);

            n = 0;
            while (q.size() > 0 && n < 200) begin @(posedge clk); n++; end
            if (q.size() > 0) begin
                checks++; errors++;
                $display("FAIL L%0d drain actual=%0d pending required=0", L, q.size());
            end
            idle(2);
            fin = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 20000) begin
            checks++; errors++;
            $display("FAIL global_timeout actual=%0d cycles required=<20000", n);
        end
        #20;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
